if_stage: RTL and testbench

//   Instruction-fetch stage of the 5-stage LoongArch pipeline; sits directly upstream of id_stage.

---
 rtl/if_stage.sv | 70 +++++++
 tb/tb_if_stage.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction-fetch stage: next-PC generation, sync SRAM fetch, stall buffer, redirect kill
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_allowin,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        fs_to_ds_valid,
  output logic [63:0] fs_to_ds_bus,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata
);

  logic        fs_valid_q, fs_valid_d;
  logic [31:0] fs_pc_q, fs_pc_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic        inst_buf_valid_q, inst_buf_valid_d;

  logic [31:0] nextpc;
  logic [31:0] fs_inst;
  logic        fs_allowin;

  assign nextpc     = br_taken ? br_target : fs_pc_q + 32'd4;
  assign fs_allowin = ~fs_valid_q | ds_allowin | br_taken;

  assign inst_sram_en    = ~reset & fs_allowin;
  assign inst_sram_we    = 4'h0;
  assign inst_sram_addr  = nextpc;
  assign inst_sram_wdata = 32'h0;

  // SRAM output is only trustworthy on the cycle after the read; afterwards the buffer holds it.
  assign fs_inst        = inst_buf_valid_q ? inst_buf_q : inst_sram_rdata;
  assign fs_to_ds_valid = ~reset & fs_valid_q & ~br_taken;
  assign fs_to_ds_bus   = {fs_pc_q, fs_inst};

  always_comb begin
    fs_valid_d       = fs_valid_q;
    fs_pc_d          = fs_pc_q;
    inst_buf_d       = inst_buf_q;
    inst_buf_valid_d = inst_buf_valid_q;
    if (inst_sram_en) begin
      fs_valid_d       = 1'b1;
      fs_pc_d          = nextpc;
      inst_buf_valid_d = 1'b0;
    end else if (fs_valid_q & ~inst_buf_valid_q) begin
      inst_buf_d       = inst_sram_rdata;
      inst_buf_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fs_valid_q       <= 1'b0;
      fs_pc_q          <= RESET_PC - 32'd4;
      inst_buf_q       <= 32'h0;
      inst_buf_valid_q <= 1'b0;
    end else begin
      fs_valid_q       <= fs_valid_d;
      fs_pc_q          <= fs_pc_d;
      inst_buf_q       <= inst_buf_d;
      inst_buf_valid_q <= inst_buf_valid_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed and random-backpressure bench for if_stage
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ds_allowin;
  logic        br_taken;
  logic [31:0] br_target;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;

  logic [31:0] sram_q;
  logic        force_dead;

  int tests_run = 0;
  int tests_failed = 0;

  if_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ds_allowin      (ds_allowin),
    .br_taken        (br_taken),
    .br_target       (br_target),
    .fs_to_ds_valid  (fs_to_ds_valid),
    .fs_to_ds_bus    (fs_to_ds_bus),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_we    (inst_sram_we),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0f0f_3c3c;
  endfunction

  always_ff @(posedge clk) begin
    if (inst_sram_en) sram_q <= mem_fn(inst_sram_addr);
  end

  assign inst_sram_rdata = force_dead ? 32'hdeadbeef : sram_q;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic [31:0] p;
  logic [31:0] exp_pc;
  int          accepted;

  initial begin
    reset = 1'b1; ds_allowin = 1'b1; br_taken = 1'b0; br_target = 32'h0; force_dead = 1'b0;
    tick(); tick(); settle();
    check("rst_en", {63'd0, inst_sram_en}, 64'd0);
    check("rst_valid", {63'd0, fs_to_ds_valid}, 64'd0);
    check("rst_we", {60'd0, inst_sram_we}, 64'd0);
    check("rst_wdata", {32'd0, inst_sram_wdata}, 64'd0);

    // release: first fetch is RESET_PC, bus pc lags addr by one cycle
    tick(); reset = 1'b0; settle();
    check("rel_en", {63'd0, inst_sram_en}, 64'd1);
    check("rel_addr", {32'd0, inst_sram_addr}, {32'd0, 32'h1c000000});
    check("rel_valid", {63'd0, fs_to_ds_valid}, 64'd0);
    for (int k = 1; k <= 4; k++) begin
      tick(); settle();
      p = 32'h1c000000 + 32'(4 * k);
      check("strm_addr", {32'd0, inst_sram_addr}, {32'd0, p});
      check("strm_valid", {63'd0, fs_to_ds_valid}, 64'd1);
      check("strm_bus", fs_to_ds_bus, {p - 32'd4, mem_fn(p - 32'd4)});
    end

    // stall 3 cycles, rdata corrupted after the first
    p = fs_to_ds_bus[63:32];
    for (int k = 0; k < 3; k++) begin
      if (k == 0) begin tick(); ds_allowin = 1'b0; settle(); end
      else begin tick(); force_dead = 1'b1; settle(); end
      check("stall_en", {63'd0, inst_sram_en}, 64'd0);
      check("stall_valid", {63'd0, fs_to_ds_valid}, 64'd1);
      check("stall_bus", fs_to_ds_bus, {p + 32'd4, mem_fn(p + 32'd4)});
    end
    tick(); ds_allowin = 1'b1; force_dead = 1'b0; settle();
    check("unstall_en", {63'd0, inst_sram_en}, 64'd1);
    check("unstall_addr", {32'd0, inst_sram_addr}, {32'd0, p + 32'd8});
    check("unstall_bus", fs_to_ds_bus, {p + 32'd4, mem_fn(p + 32'd4)});
    tick(); settle();
    check("post_stall_bus", fs_to_ds_bus, {p + 32'd8, mem_fn(p + 32'd8)});

    // redirect
    br_taken = 1'b1; br_target = 32'h1c000100; settle();
    check("br_valid", {63'd0, fs_to_ds_valid}, 64'd0);
    check("br_addr", {32'd0, inst_sram_addr}, {32'd0, 32'h1c000100});
    check("br_en", {63'd0, inst_sram_en}, 64'd1);
    tick(); br_taken = 1'b0; settle();
    check("br_next_valid", {63'd0, fs_to_ds_valid}, 64'd1);
    check("br_next_bus", fs_to_ds_bus, {32'h1c000100, mem_fn(32'h1c000100)});
    check("br_next_addr", {32'd0, inst_sram_addr}, {32'd0, 32'h1c000104});

    // redirect during a stall with the buffer loaded
    tick(); ds_allowin = 1'b0; settle();
    tick(); force_dead = 1'b1; settle();
    check("bstall_bus", fs_to_ds_bus, {32'h1c000104, mem_fn(32'h1c000104)});
    br_taken = 1'b1; br_target = 32'h1c000200; settle();
    check("bstall_br_valid", {63'd0, fs_to_ds_valid}, 64'd0);
    check("bstall_br_en", {63'd0, inst_sram_en}, 64'd1);
    check("bstall_br_addr", {32'd0, inst_sram_addr}, {32'd0, 32'h1c000200});
    tick(); br_taken = 1'b0; force_dead = 1'b0; settle();
    check("bstall_tgt_valid", {63'd0, fs_to_ds_valid}, 64'd1);
    check("bstall_tgt_bus", fs_to_ds_bus, {32'h1c000200, mem_fn(32'h1c000200)});
    tick(); ds_allowin = 1'b1; settle();
    check("bstall_tgt_hold", fs_to_ds_bus, {32'h1c000200, mem_fn(32'h1c000200)});

    // misaligned target passes through
    br_taken = 1'b1; br_target = 32'h1c000302; settle();
    check("mis_addr", {32'd0, inst_sram_addr}, {32'd0, 32'h1c000302});
    tick(); br_taken = 1'b0; settle();
    check("mis_bus_pc", {32'd0, fs_to_ds_bus[63:32]}, {32'd0, 32'h1c000302});

    // mid-stream reset for 2 cycles
    tick(); reset = 1'b1; settle();
    check("mrst_en0", {63'd0, inst_sram_en}, 64'd0);
    check("mrst_valid0", {63'd0, fs_to_ds_valid}, 64'd0);
    tick(); settle();
    check("mrst_en1", {63'd0, inst_sram_en}, 64'd0);
    check("mrst_valid1", {63'd0, fs_to_ds_valid}, 64'd0);
    tick(); reset = 1'b0; settle();
    check("mrst_addr", {32'd0, inst_sram_addr}, {32'd0, 32'h1c000000});
    check("mrst_rel_valid", {63'd0, fs_to_ds_valid}, 64'd0);
    tick(); settle();
    check("mrst_bus", fs_to_ds_bus, {32'h1c000000, mem_fn(32'h1c000000)});

    // random back-pressure, no branches: accepted stream must be contiguous
    exp_pc = 32'h1c000000;
    accepted = 0;
    for (int c = 0; c < 1000; c++) begin
      ds_allowin = 1'($urandom_range(0, 1));
      settle();
      if (fs_to_ds_valid && ds_allowin) begin
        check("rnd_pc", {32'd0, fs_to_ds_bus[63:32]}, {32'd0, exp_pc});
        check("rnd_inst", {32'd0, fs_to_ds_bus[31:0]}, {32'd0, mem_fn(exp_pc)});
        exp_pc = exp_pc + 32'd4;
        accepted++;
      end
      tick();
    end
    check("rnd_progress", {63'd0, accepted >= 350}, 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
